relu_act: RTL and testbench

- Fixed-point ReLU activation stage at the output of each neuron's multiply-accumulate.
- Takes the 2*DATA_WIDTH-bit signed accumulator sum and rectifies it.
- Rescales and saturates the result to a DATA_WIDTH-bit fixed-point activation.
- Single registered stage with a valid qualifier; feeds the next layer's input bus.

---
 rtl/nn_fixed_pkg.sv | 23 ++
 rtl/relu_sat_core.sv | 63 ++++++
 rtl/relu_act.sv | 53 +++++
 tb/tb_relu_act.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neural-net datapath.
// Default widths, accumulator width rule and saturation constants.
package nn_fixed_pkg;

  localparam int DATA_WIDTH_DEF       = 16;
  localparam int WEIGHT_INT_WIDTH_DEF = 4;

  // A product of two DATA_WIDTH operands is accumulated at double width.
  function automatic int acc_width(input int dw);
    return 2 * dw;
  endfunction

  // Largest positive activation: {1'b0, all ones}.
  function automatic logic [63:0] pos_sat_val(input int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most negative activation: {1'b1, all zeros}.
  function automatic logic [63:0] neg_sat_val(input int dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/relu_sat_core.sv
// Combinational ReLU: rectify, rescale and saturate an accumulator sum.
// Ports: x (signed acc sum) -> out (activation), sat (result clamped).
// Optional: define LEAKY_RELU_EN for a leaky negative slope.
module relu_sat_core
  import nn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int WEIGHT_INT_WIDTH = WEIGHT_INT_WIDTH_DEF
`ifdef LEAKY_RELU_EN
  ,
  parameter int LEAK_SHIFT       = 3
`endif
) (
  input  logic [2*DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    sat
);

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam int S     = ACC_W - 1;
  localparam int LSB   = S - WEIGHT_INT_WIDTH - DATA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] POS_SAT =
    DATA_WIDTH'(pos_sat_val(DATA_WIDTH));
`ifdef LEAKY_RELU_EN
  localparam logic [DATA_WIDTH-1:0] NEG_SAT =
    DATA_WIDTH'(neg_sat_val(DATA_WIDTH));
`endif

  logic [WEIGHT_INT_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0]       sl;
  logic                        unused_lsbs;

  assign u  = x[S-1 -: WEIGHT_INT_WIDTH];
  assign sl = x[S-WEIGHT_INT_WIDTH -: DATA_WIDTH];
  // Fraction bits below the output slice are truncated.
  assign unused_lsbs = ^x[LSB-1:0];

  always_comb begin
    out = sl;
    sat = 1'b0;
    if (!x[S]) begin
      // Any set overflow bit means the value exceeds the output range.
      if (|u) begin
        out = POS_SAT;
        sat = 1'b1;
      end
    end else begin
`ifdef LEAKY_RELU_EN
      // Overflow bits must be pure sign extension to fit.
      if (!(&u)) begin
        out = NEG_SAT;
        sat = 1'b1;
      end else begin
        out = $signed(sl) >>> LEAK_SHIFT;
      end
`else
      out = '0;
`endif
    end
  end

endmodule

// File: rtl/relu_act.sv
// Registered ReLU activation stage with valid qualifier.
// Ports: clk, rst, x, in_valid -> out, out_valid, sat. Option: LEAKY_RELU_EN.
module relu_act
  import nn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int WEIGHT_INT_WIDTH = WEIGHT_INT_WIDTH_DEF,
  parameter int LEAK_SHIFT       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] x,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    out_valid,
  output logic                    sat
);

  if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_shift
    $error("relu_act: LEAK_SHIFT out of range");
  end

  logic [DATA_WIDTH-1:0] core_out;
  logic                  core_sat;

  relu_sat_core #(
    .DATA_WIDTH       (DATA_WIDTH),
    .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH)
`ifdef LEAKY_RELU_EN
    ,
    .LEAK_SHIFT       (LEAK_SHIFT)
`endif
  ) u_core (
    .x   (x),
    .out (core_out),
    .sat (core_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= core_out;
        sat <= core_sat;
      end
    end
  end

endmodule

// File: tb/tb_relu_act.sv
// Self-checking bench for relu_act (DATA_WIDTH=16, WEIGHT_INT_WIDTH=4).
// Arithmetic reference model; randomized and directed scenarios.
module tb_relu_act;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic        sat;

  int errors = 0;
  int checks = 0;

  relu_act #(
    .DATA_WIDTH       (16),
    .WEIGHT_INT_WIDTH (4),
    .LEAK_SHIFT       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Value-level model: x is a Q.12 number; activation is floor(x/2^12)
  // clamped to the signed 16-bit range.
  function automatic logic [16:0] model(input logic [31:0] xv);
    longint v;
    longint q;
    longint r;
    logic [16:0] res;
    v = longint'($signed(xv));
    q = v >>> 12;
    if (v >= 0) begin
      if (q > 32767) res = {1'b1, 16'h7FFF};
      else res = {1'b0, q[15:0]};
    end else begin
`ifdef LEAKY_RELU_EN
      if (q < -32768) begin
        res = {1'b1, 16'h8000};
      end else begin
        r = q >>> 3;
        res = {1'b0, r[15:0]};
      end
`else
      res = 17'd0;
`endif
    end
    return res;
  endfunction

  task automatic step(input logic [31:0] xv, input logic v);
    @(negedge clk);
    x = xv;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    x = 32'h0123_4000;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0 || out_valid !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h v=%b sat=%b want 0000 0 0",
               out, out_valid, sat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] xs [8];
    logic [16:0] exp;
    int n;
    xs[0] = 32'h0001_0000;
    xs[1] = 32'h0123_4000;
    xs[2] = 32'h0800_0000;
    xs[3] = 32'h7FFF_FFFF;
    xs[4] = 32'h0000_0000;
    xs[5] = 32'hFFFF_0000;
    xs[6] = 32'h8000_0000;
    xs[7] = 32'h07FF_FFFF;
    n = 8;
    for (int i = 0; i < n; i++) begin
      step(xs[i], 1'b1);
      exp = model(xs[i]);
      checks++;
      if (out_valid !== 1'b1 || out !== exp[15:0] || sat !== exp[16]) begin
        errors++;
        $display("FAIL directed x=%h: out=%h sat=%b v=%b want %h %b 1",
                 xs[i], out, sat, out_valid, exp[15:0], exp[16]);
      end
    end
    // Spec spot values, independent of the model.
    step(32'h0001_0000, 1'b1);
    checks++;
    if (out !== 16'h0010 || sat !== 1'b0) begin
      errors++;
      $display("FAIL spot_0010: out=%h sat=%b want 0010 0", out, sat);
    end
    step(32'h0800_0000, 1'b1);
    checks++;
    if (out !== 16'h7FFF || sat !== 1'b1) begin
      errors++;
      $display("FAIL spot_pos_sat: out=%h sat=%b want 7fff 1", out, sat);
    end
    step(32'hFFFF_0000, 1'b1);
    checks++;
`ifdef LEAKY_RELU_EN
    if (out !== 16'hFFFE || sat !== 1'b0) begin
      errors++;
      $display("FAIL spot_leak: out=%h sat=%b want fffe 0", out, sat);
    end
    step(32'h8000_0000, 1'b1);
    checks++;
    if (out !== 16'h8000 || sat !== 1'b1) begin
      errors++;
      $display("FAIL spot_neg_sat: out=%h sat=%b want 8000 1", out, sat);
    end
`else
    if (out !== 16'h0000 || sat !== 1'b0) begin
      errors++;
      $display("FAIL spot_neg: out=%h sat=%b want 0000 0", out, sat);
    end
`endif
  endtask

  task automatic test_random;
    logic [31:0] xv;
    logic        v;
    logic [16:0] m;
    logic [15:0] exp_out;
    logic        exp_sat;
    // Establish a known held value first.
    step(32'h0123_4000, 1'b1);
    exp_out = 16'h1234;
    exp_sat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: xv = $urandom & 32'h07FF_FFFF;
        1: xv = $urandom | 32'hF800_0000;
        2: xv = $urandom & 32'h0FFF_FFFF;
        default: xv = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      step(xv, v);
      if (v) begin
        m = model(xv);
        exp_out = m[15:0];
        exp_sat = m[16];
      end
      checks++;
      if (out_valid !== v || out !== exp_out || sat !== exp_sat) begin
        errors++;
        $display("FAIL random x=%h iv=%b: out=%h sat=%b v=%b want %h %b %b",
                 xv, v, out, sat, out_valid, exp_out, exp_sat, v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xv;
    logic [16:0] m;
    logic [16:0] last;
    int pulses;
    pulses = 0;
    last = '0;
    for (int i = 0; i < 4; i++) begin
      xv = $urandom & 32'h0FFF_FFFF;
      step(xv, 1'b1);
      m = model(xv);
      last = m;
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (out_valid !== 1'b1 || out !== m[15:0] || sat !== m[16]) begin
        errors++;
        $display("FAIL b2b[%0d]: out=%h sat=%b v=%b want %h %b 1",
                 i, out, sat, out_valid, m[15:0], m[16]);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d want 4", pulses);
    end
    for (int i = 0; i < 3; i++) begin
      step($urandom, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out !== last[15:0] || sat !== last[16]) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: out=%h sat=%b v=%b want %h %b 0",
                 i, out, sat, out_valid, last[15:0], last[16]);
      end
    end
  endtask

  task automatic test_async_reset;
    step(32'h0800_0000, 1'b1);
    step(32'h0123_4000, 1'b1);
    // Assert reset between edges and look before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0 || out_valid !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h v=%b sat=%b want 0000 0 0",
               out, out_valid, sat);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(32'h0800_0000, 1'b0);
    step(32'h0123_4000, 1'b0);
    checks++;
    if (out !== 16'h0 || out_valid !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: out=%h v=%b sat=%b want 0000 0 0",
               out, out_valid, sat);
    end
    step(32'h0123_4000, 1'b1);
    checks++;
    if (out !== 16'h1234 || out_valid !== 1'b1 || sat !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_first: out=%h v=%b sat=%b want 1234 1 0",
               out, out_valid, sat);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
